bcd_countdown_timer: RTL and testbench

// - mm:ss countdown timer. Sits directly upstream of the VGA painter and drives its

---
 rtl/bcd_countdown_timer.sv | 196 +++++++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: mm:ss countdown timer feeding the VGA painter's
// four BCD digit inputs.
//
// Optional feature macro: TIMER_ALARM_EN
//   defined   - alarm toggles every ALARM_DIV cycles while in DONE
//   undefined - alarm tied to 0, no alarm counter
//
// Ports:
//   clk                 system clock (100 MHz)
//   reset               asynchronous, active-low reset
//   start, stop         1-cycle control pulses (synchronised, debounced)
//   preset_min_dec..    preset digits, BCD (out-of-range values clamped)
//   preset_sec_unit
//   mDecimal, mUnit,    current count, BCD, registered
//   sDecimal, sUnit
//   actualState         state code: IDLE=0 RUN=1 PAUSE=2 DONE=3
//   finish              high while in DONE
//   alarm               buzzer/LED drive, active only in DONE
module bcd_countdown_timer #(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned ALARM_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] preset_min_dec,
  input  logic [3:0] preset_min_unit,
  input  logic [3:0] preset_sec_dec,
  input  logic [3:0] preset_sec_unit,
  output logic [3:0] mDecimal,
  output logic [3:0] mUnit,
  output logic [3:0] sDecimal,
  output logic [3:0] sUnit,
  output logic [2:0] actualState,
  output logic       finish,
  output logic       alarm
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    DONE  = 3'd3
  } state_t;

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  if (TICK_DIV < 1 || ALARM_DIV < 1) begin : g_bad_params
    $error("bcd_countdown_timer: TICK_DIV and ALARM_DIV must be at least 1");
  end

  state_t        state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [3:0]    md_nx, mu_nx, sd_nx, su_nx;
  logic [3:0]    c_md, c_mu, c_sd, c_su;
  logic [3:0]    d_md, d_mu, d_sd, d_su;
  logic          preset_zero, dec_zero, tick_tc;

  // Preset clamp: digits above 9 read as 9, seconds tens above 5 read as 5
  always_comb begin
    c_md = (preset_min_dec  > 4'd9) ? 4'd9 : preset_min_dec;
    c_mu = (preset_min_unit > 4'd9) ? 4'd9 : preset_min_unit;
    c_sd = (preset_sec_dec  > 4'd5) ? 4'd5 : preset_sec_dec;
    c_su = (preset_sec_unit > 4'd9) ? 4'd9 : preset_sec_unit;
    preset_zero = ((c_md | c_mu | c_sd | c_su) == 4'd0);
  end

  // One-second decrement with borrow chain su -> sd -> mu -> md.
  // RUN is never entered at 00:00, so mDecimal cannot underflow.
  always_comb begin
    d_md = mDecimal;
    d_mu = mUnit;
    d_sd = sDecimal;
    d_su = sUnit - 4'd1;
    if (sUnit == 4'd0) begin
      d_su = 4'd9;
      if (sDecimal == 4'd0) begin
        d_sd = 4'd5;
        if (mUnit == 4'd0) begin
          d_mu = 4'd9;
          d_md = mDecimal - 4'd1;
        end else begin
          d_mu = mUnit - 4'd1;
        end
      end else begin
        d_sd = sDecimal - 4'd1;
      end
    end
    dec_zero = ((d_md | d_mu | d_sd | d_su) == 4'd0);
  end

  assign tick_tc = (presc == PW'(TICK_DIV - 1));

  // Next-state and datapath; stop takes priority over start everywhere.
  // The prescaler only advances on RUN cycles without stop, so the
  // count spent before a pause is preserved across it.
  always_comb begin
    state_nx = state;
    presc_nx = presc;
    md_nx    = mDecimal;
    mu_nx    = mUnit;
    sd_nx    = sDecimal;
    su_nx    = sUnit;
    case (state)
      IDLE: begin
        md_nx = c_md;
        mu_nx = c_mu;
        sd_nx = c_sd;
        su_nx = c_su;
        if (!stop && start) begin
          presc_nx = '0;
          state_nx = preset_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nx = PAUSE;
        end else if (tick_tc) begin
          presc_nx = '0;
          md_nx    = d_md;
          mu_nx    = d_mu;
          sd_nx    = d_sd;
          su_nx    = d_su;
          if (dec_zero) state_nx = DONE;
        end else begin
          presc_nx = presc + PW'(1);
        end
      end
      PAUSE: begin
        if (stop)       state_nx = IDLE;
        else if (start) state_nx = RUN;
      end
      DONE: begin
        md_nx = '0;
        mu_nx = '0;
        sd_nx = '0;
        su_nx = '0;
        if (start || stop) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      presc    <= '0;
      mDecimal <= '0;
      mUnit    <= '0;
      sDecimal <= '0;
      sUnit    <= '0;
      finish   <= 1'b0;
    end else begin
      state    <= state_nx;
      presc    <= presc_nx;
      mDecimal <= md_nx;
      mUnit    <= mu_nx;
      sDecimal <= sd_nx;
      sUnit    <= su_nx;
      finish   <= (state_nx == DONE);
    end
  end

  assign actualState = state;

`ifdef TIMER_ALARM_EN
  localparam int unsigned AW = (ALARM_DIV > 1) ? $clog2(ALARM_DIV) : 1;

  logic [AW-1:0] alarm_cnt;

  // Square wave starting high on DONE entry, counter cleared outside DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_cnt <= '0;
      alarm     <= 1'b0;
    end else if (state_nx == DONE) begin
      if (state != DONE) begin
        alarm_cnt <= '0;
        alarm     <= 1'b1;
      end else if (alarm_cnt == AW'(ALARM_DIV - 1)) begin
        alarm_cnt <= '0;
        alarm     <= ~alarm;
      end else begin
        alarm_cnt <= alarm_cnt + AW'(1);
      end
    end else begin
      alarm_cnt <= '0;
      alarm     <= 1'b0;
    end
  end
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer with TICK_DIV=4, ALARM_DIV=2.
module tb_bcd_countdown_timer;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_PAUSE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [15:0] preset = 16'h0130;
  logic [3:0] mDecimal, mUnit, sDecimal, sUnit;
  logic [2:0] actualState;
  logic       finish, alarm;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  bcd_countdown_timer #(
    .TICK_DIV (4),
    .ALARM_DIV(2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .preset_min_dec (preset[15:12]),
    .preset_min_unit(preset[11:8]),
    .preset_sec_dec (preset[7:4]),
    .preset_sec_unit(preset[3:0]),
    .mDecimal       (mDecimal),
    .mUnit          (mUnit),
    .sDecimal       (sDecimal),
    .sUnit          (sUnit),
    .actualState    (actualState),
    .finish         (finish),
    .alarm          (alarm)
  );

  typedef struct {
    logic        start;
    logic        stop;
    logic [15:0] preset;
    logic [15:0] exp_digits;
    logic [2:0]  exp_state;
    logic        exp_finish;
    logic        exp_alarm;
  } vec_t;

  vec_t vecs[$];

  function automatic logic al(input logic v);
`ifdef TIMER_ALARM_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] dig, input logic [2:0] st,
                           input logic fin, input logic alm);
    check({tag, " digits"}, {16'h0, mDecimal, mUnit, sDecimal, sUnit}, {16'h0, dig});
    check({tag, " state"}, {29'h0, actualState}, {29'h0, st});
    check({tag, " finish"}, {31'h0, finish}, {31'h0, fin});
    check({tag, " alarm"}, {31'h0, alarm}, {31'h0, alm});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic st, input logic sp, input logic [15:0] p,
                     input logic [15:0] d, input logic [2:0] s, input logic f, input logic a);
    vec_t v;
    v.start = st; v.stop = sp; v.preset = p;
    v.exp_digits = d; v.exp_state = s; v.exp_finish = f; v.exp_alarm = a;
    vecs.push_back(v);
  endtask

  initial begin
    // start, stop, preset -> expected digits, state, finish, alarm after the edge
    add(0, 0, 16'h0130, 16'h0130, S_IDLE,  0, 0);
    add(0, 0, 16'h9F7C, 16'h9959, S_IDLE,  0, 0);   // clamp
    add(1, 0, 16'h0000, 16'h0000, S_DONE,  1, al(1)); // zero preset -> DONE
    add(0, 0, 16'h0000, 16'h0000, S_DONE,  1, al(1));
    add(1, 0, 16'h0000, 16'h0000, S_IDLE,  0, 0);   // start leaves DONE
    add(1, 1, 16'h0000, 16'h0000, S_IDLE,  0, 0);   // stop wins in IDLE
    add(0, 0, 16'h0002, 16'h0002, S_IDLE,  0, 0);
    add(1, 0, 16'h0002, 16'h0002, S_RUN,   0, 0);
    add(0, 0, 16'h0002, 16'h0002, S_RUN,   0, 0);
    add(0, 0, 16'h0002, 16'h0002, S_RUN,   0, 0);
    add(0, 0, 16'h0002, 16'h0002, S_RUN,   0, 0);
    add(0, 0, 16'h0002, 16'h0001, S_RUN,   0, 0);   // 4th edge after start
    add(1, 1, 16'h0002, 16'h0001, S_PAUSE, 0, 0);   // stop wins in RUN
    add(0, 0, 16'h0002, 16'h0001, S_PAUSE, 0, 0);
    add(0, 1, 16'h0002, 16'h0001, S_IDLE,  0, 0);   // stop in PAUSE
    add(0, 0, 16'h0002, 16'h0002, S_IDLE,  0, 0);
    add(1, 0, 16'h0002, 16'h0002, S_RUN,   0, 0);
    add(0, 0, 16'h0002, 16'h0002, S_RUN,   0, 0);
    add(0, 0, 16'h0002, 16'h0002, S_RUN,   0, 0);
    add(0, 0, 16'h0002, 16'h0002, S_RUN,   0, 0);
    add(0, 0, 16'h0002, 16'h0001, S_RUN,   0, 0);
    add(0, 0, 16'h0002, 16'h0001, S_RUN,   0, 0);
    add(0, 0, 16'h0002, 16'h0001, S_RUN,   0, 0);
    add(0, 0, 16'h0002, 16'h0001, S_RUN,   0, 0);
    add(0, 0, 16'h0002, 16'h0000, S_DONE,  1, al(1)); // decrement to zero
    add(0, 1, 16'h0002, 16'h0000, S_IDLE,  0, 0);
    add(0, 0, 16'h0002, 16'h0002, S_IDLE,  0, 0);
    add(0, 0, 16'h1000, 16'h1000, S_IDLE,  0, 0);
    add(1, 0, 16'h1000, 16'h1000, S_RUN,   0, 0);
    add(0, 0, 16'h1000, 16'h1000, S_RUN,   0, 0);
    add(0, 0, 16'h1000, 16'h1000, S_RUN,   0, 0);
    add(0, 0, 16'h1000, 16'h1000, S_RUN,   0, 0);
    add(0, 0, 16'h1000, 16'h0959, S_RUN,   0, 0);   // full borrow chain
    add(0, 1, 16'h1000, 16'h0959, S_PAUSE, 0, 0);
    add(0, 1, 16'h1000, 16'h0959, S_IDLE,  0, 0);
    add(0, 0, 16'h1000, 16'h1000, S_IDLE,  0, 0);

    // Reset: assert asynchronously, hold across one edge
    #1 reset = 1'b0;
    #2 check_all("reset async", 16'h0000, S_IDLE, 0, 0);
    step();
    check_all("reset held", 16'h0000, S_IDLE, 0, 0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      start  = vecs[i].start;
      stop   = vecs[i].stop;
      preset = vecs[i].preset;
      step();
      start = 1'b0;
      stop  = 1'b0;
      check_all($sformatf("row%0d", i), vecs[i].exp_digits, vecs[i].exp_state,
                vecs[i].exp_finish, vecs[i].exp_alarm);
    end

    // 01:00 full countdown and alarm pattern
    preset = 16'h0100;
    step();
    check_all("m1 idle", 16'h0100, S_IDLE, 0, 0);
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    check_all("m1 edge3", 16'h0100, S_RUN, 0, 0);
    step();
    check_all("m1 first tick", 16'h0059, S_RUN, 0, 0);
    repeat (232) step();
    check_all("m1 tick59", 16'h0001, S_RUN, 0, 0);
    repeat (3) step();
    check_all("m1 edge239", 16'h0001, S_RUN, 0, 0);
    step();
    check_all("m1 done", 16'h0000, S_DONE, 1, al(1));
    step();
    check_all("m1 alarm1", 16'h0000, S_DONE, 1, al(1));
    step();
    check_all("m1 alarm2", 16'h0000, S_DONE, 1, al(0));
    step();
    check_all("m1 alarm3", 16'h0000, S_DONE, 1, al(0));
    step();
    check_all("m1 alarm4", 16'h0000, S_DONE, 1, al(1));
    stop = 1'b1; step(); stop = 1'b0;
    check_all("m1 exit", 16'h0000, S_IDLE, 0, 0);

    // 00:10 pause for 20 cycles mid-prescale, resume without tick loss
    preset = 16'h0010;
    step();
    start = 1'b1; step(); start = 1'b0;
    check_all("p start", 16'h0010, S_RUN, 0, 0);
    repeat (2) step();
    stop = 1'b1; step(); stop = 1'b0;
    check_all("p paused", 16'h0010, S_PAUSE, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("p frozen%0d digits", i), {16'h0, mDecimal, mUnit, sDecimal, sUnit}, 32'h0010);
      check($sformatf("p frozen%0d state", i), {29'h0, actualState}, {29'h0, S_PAUSE});
    end
    start = 1'b1; step(); start = 1'b0;
    check_all("p resume", 16'h0010, S_RUN, 0, 0);
    step();
    check_all("p resume+1", 16'h0010, S_RUN, 0, 0);
    step();
    check_all("p resume+2", 16'h0009, S_RUN, 0, 0);

    // Asynchronous reset in the middle of RUN
    step();
    #2 reset = 1'b0;
    #1 check_all("rst midrun", 16'h0000, S_IDLE, 0, 0);
    step();
    check_all("rst midrun held", 16'h0000, S_IDLE, 0, 0);
    reset = 1'b1;
    step();
    check_all("rst reload", 16'h0010, S_IDLE, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
